// File: rtl/uart_mmio_if.sv
// CPU data-bus view of the UART: chip select, strobes, word offset, write lanes,
// and the combinational read-back word.
interface uart_mmio_if;
    logic        cs_n;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs_n, we, re, addr, byte_enable, wdata, input rdata);
    modport slave  (input cs_n, we, re, addr, byte_enable, wdata, output rdata);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped UART: TX FIFO feeding a baud-rate shifter, RX synchronizer with a
// mid-bit sampler and a one-byte holding register with sticky error flags.
module uart_mmio #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int TX_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    uart_mmio_if.slave bus,
    output logic       UART_TXD,
    input  logic       UART_RXD,
    output logic [1:0] tx_state_o,
    output logic [1:0] rx_state_o
);
    localparam int DIV  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(TX_DEPTH);
    localparam int PW   = AW + 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Bus semantics: a transfer happens on any clock edge where cs_n=0; we=1 is a
    // write, re=1 with we=0 is a read with side effects. There is no wait state,
    // so every access completes in the cycle it is presented.
    logic push_req, rx_pop, clr_overrun, clr_frame_err;

    always_comb begin
        push_req      = ~bus.cs_n & bus.we & (bus.addr == 2'd0) & bus.byte_enable[0];
        rx_pop        = ~bus.cs_n & bus.re & ~bus.we & (bus.addr == 2'd0);
        clr_overrun   = ~bus.cs_n & bus.we & (bus.addr == 2'd1) & bus.wdata[3];
        clr_frame_err = ~bus.cs_n & bus.we & (bus.addr == 2'd1) & bus.wdata[4];
    end

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:8], bus.byte_enable[3:1]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem_q [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          fifo_empty, tx_full, tx_push, tx_pop;
    logic [7:0]    fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign tx_full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the head slot, so a push on a full FIFO still lands.
    assign tx_push    = push_req && (!tx_full || tx_pop);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (tx_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (tx_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.wdata[7:0];
    end

    // ---------------- TX shifter ----------------
    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, tx_line;
    logic          tx_busy;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_head;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                tx_line = 1'b0;
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                tx_line = tx_shift_q[0];
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                tx_line = 1'b1;
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    // Back-to-back frames: go straight to the next start bit.
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_head;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign tx_busy = (tx_state_q != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= tx_line;
        end
    end

    assign UART_TXD   = txd_q;
    assign tx_state_o = tx_state_q;

    // ---------------- RX sampler ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_done_ok, rx_done_err;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done_ok  = 1'b0;
        rx_done_err = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Half a bit in: a line that is high again was a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = ST_IDLE;
                    rx_done_ok  = rx_s2_q;
                    rx_done_err = ~rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // Hardware set has priority over software clear on every sticky flag.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (rx_done_ok) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end else if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
        if (rx_done_ok && rx_valid_q && !rx_pop) overrun_d = 1'b1;
        else if (clr_overrun)                    overrun_d = 1'b0;
        if (rx_done_err)        frame_err_d = 1'b1;
        else if (clr_frame_err) frame_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= UART_RXD;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_state_o = rx_state_q;

    always_comb begin
        bus.rdata = '0;
        if (!bus.cs_n) begin
            case (bus.addr)
                2'd0:    bus.rdata = {24'b0, rx_data_q};
                2'd1:    bus.rdata = {27'b0, frame_err_q, overrun_q, tx_busy, rx_valid_q, tx_full};
                default: bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with DIV=16: register map vectors, TX framing,
// FIFO full/back-to-back frames, loopback, RX error flags and edge-coincidence cases.
module tb_uart_mmio;
    localparam int CLOCK_FREQ = 64;
    localparam int BAUD_RATE  = 4;
    localparam int TX_DEPTH   = 4;
    localparam int DIV        = 16;
    localparam int FRAME      = 10 * DIV;

    typedef struct {
        logic        cs_n;
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  rd_addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       txd;
    logic       rxd_drv;
    logic       loop_en;
    logic       rxd_line;
    logic [1:0] tx_state, rx_state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    uart_mmio_if bus ();

    uart_mmio #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .TX_DEPTH  (TX_DEPTH)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus),
        .UART_TXD  (txd),
        .UART_RXD  (rxd_line),
        .tx_state_o(tx_state),
        .rx_state_o(rx_state)
    );

    assign rxd_line = loop_en ? txd : rxd_drv;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic bus_idle();
        bus.cs_n = 1'b1; bus.we = 1'b0; bus.re = 1'b0;
        bus.addr = 2'd0; bus.byte_enable = 4'h0; bus.wdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.cs_n = 1'b0; bus.we = 1'b1; bus.re = 1'b0;
        bus.addr = a; bus.byte_enable = be; bus.wdata = d;
        tick();
        bus_idle();
    endtask

    task automatic bus_pop();
        bus.cs_n = 1'b0; bus.we = 1'b0; bus.re = 1'b1; bus.addr = 2'd0;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.cs_n = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = a;
        #1;
        d = bus.rdata;
        bus_idle();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = bits[i];
            repeat (DIV) tick();
        end
        rxd_drv = 1'b1;
    endtask

    task automatic wait_rx_valid(input int budget, output int at);
        logic [31:0] st;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            bus_read(2'd1, st);
            if (st[1]) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    // ---------------- stimulus + scoreboard ----------------
    vec_t        vecs[7];
    logic [7:0]  exp_bytes[6];
    logic [31:0] rd;
    logic [31:0] st;
    logic [9:0]  frame_bits;
    int          n0, s0, at, lat;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 32'h0,        2'd1, 32'h0, "pop_when_empty"};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 32'hAB,       2'd1, 32'h0, "unselected_write"};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd2, 4'hF, 32'hFFFFFFFF, 2'd2, 32'h0, "addr2_write"};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'hF, 32'hFFFFFFFF, 2'd3, 32'h0, "addr3_write"};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'hE, 32'h77,       2'd1, 32'h0, "lane0_disabled"};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd1, 4'hF, 32'h18,       2'd1, 32'h0, "status_clear"};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0, "data_reset"};
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'h03;
        exp_bytes[3] = 8'h04; exp_bytes[4] = 8'h05; exp_bytes[5] = 8'h07;

        bus_idle();
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        n_rst   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {31'b0, txd}, 32'h1);
        n_rst = 1'b1;
        tick();
        bus_read(2'd1, rd); check("reset_status", rd, 32'h0);
        bus_read(2'd0, rd); check("reset_data", rd, 32'h0);
        check("reset_tx_state", {30'b0, tx_state}, 32'h0);
        check("reset_rx_state", {30'b0, rx_state}, 32'h0);

        // Register map vectors
        for (int i = 0; i < 7; i++) begin
            bus.cs_n = vecs[i].cs_n; bus.we = vecs[i].we; bus.re = vecs[i].re;
            bus.addr = vecs[i].addr; bus.byte_enable = vecs[i].be; bus.wdata = vecs[i].wdata;
            tick();
            bus_idle();
            bus_read(vecs[i].rd_addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end

        // Reset asserted during a start bit
        bus_write(2'd0, 32'h00, 4'h1);
        n0 = cyc;
        goto_cyc(n0 + 10);
        check("rst_pre_txd", {31'b0, txd}, 32'h0);
        #1 n_rst = 1'b0;
        #1 check("rst_txd_async", {31'b0, txd}, 32'h1);
        bus_read(2'd1, rd); check("rst_status_in_reset", rd, 32'h0);
        tick(); tick();
        n_rst = 1'b1;
        tick();
        bus_read(2'd1, rd); check("rst_status_after", rd, 32'h0);
        check("rst_txd_after", {31'b0, txd}, 32'h1);

        // Single byte 0x55
        repeat (4) tick();
        bus_write(2'd0, 32'h55, 4'h1);
        n0 = cyc;
        goto_cyc(n0 + 1);
        check("tx55_idle_n1", {31'b0, txd}, 32'h1);
        goto_cyc(n0 + 2);
        check("tx55_start_n2", {31'b0, txd}, 32'h0);
        bus_read(2'd1, rd); check("tx55_busy", rd, 32'h4);
        bus.cs_n = 1'b1; bus.addr = 2'd1;
        #1 check("rdata_cs_high", bus.rdata, 32'h0);
        bus_idle();
        frame_bits = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) begin
            goto_cyc(n0 + 10 + DIV * b);
            check($sformatf("tx55_bit%0d", b), {31'b0, txd}, {31'b0, frame_bits[b]});
        end
        goto_cyc(n0 + FRAME + 2);
        bus_read(2'd1, rd); check("tx55_done_status", rd, 32'h0);

        // FIFO full, dropped push, push+pop on full, back-to-back frames
        repeat (4) tick();
        for (int i = 1; i <= 6; i++) bus_write(2'd0, i, 4'h1);
        n0 = cyc - 5;
        bus_read(2'd1, rd); check("fifo_full_status", rd, 32'h5);
        for (int f = 0; f < 6; f++) begin
            frame_bits = {1'b1, exp_bytes[f], 1'b0};
            for (int b = 0; b < 10; b++) begin
                goto_cyc(n0 + 10 + FRAME * f + DIV * b);
                check($sformatf("fifo_f%0d_bit%0d", f, b), {31'b0, txd}, {31'b0, frame_bits[b]});
            end
            if (f == 0) begin
                goto_cyc(n0 + FRAME);
                bus_write(2'd0, 32'h07, 4'h1);
                bus_read(2'd1, rd); check("push_pop_on_full", rd, 32'h5);
            end
        end
        goto_cyc(n0 + 6 * FRAME + 4);
        bus_read(2'd1, rd); check("fifo_drained_status", rd, 32'h0);
        check("fifo_drained_txd", {31'b0, txd}, 32'h1);

        // Loopback 0xA5
        loop_en = 1'b1;
        repeat (4) tick();
        bus_write(2'd0, 32'hA5, 4'h1);
        n0 = cyc;
        wait_rx_valid(400, at);
        check("lb_rx_valid_seen", {31'b0, at != -1}, 32'h1);
        lat = at - (n0 + 2);
        check("lb_latency_window", {31'b0, lat >= 153 && lat <= 156}, 32'h1);
        bus_read(2'd0, rd); check("lb_data", rd, 32'hA5);
        bus_pop();
        bus_read(2'd1, rd); check("lb_valid_cleared", {31'b0, rd[1]}, 32'h0);
        goto_cyc(n0 + FRAME + 4);
        loop_en = 1'b0;

        // Overrun then frame error, then software clear
        repeat (4) tick();
        send_rx(8'h3C, 1'b1);
        repeat (20) tick();
        send_rx(8'hC3, 1'b1);
        repeat (20) tick();
        bus_read(2'd1, rd); check("overrun_status", rd, 32'h0A);
        bus_read(2'd0, rd); check("overrun_data", rd, 32'hC3);
        send_rx(8'h99, 1'b0);
        repeat (20) tick();
        bus_read(2'd1, rd); check("frame_err_status", rd, 32'h1A);
        bus_read(2'd0, rd); check("frame_err_data_kept", rd, 32'hC3);
        bus_write(2'd1, 32'h18, 4'hF);
        bus_read(2'd1, rd); check("flags_cleared", rd, 32'h02);
        bus_pop();
        bus_read(2'd1, rd); check("popped_status", rd, 32'h0);

        // 3-cycle glitch is rejected
        rxd_drv = 1'b0;
        repeat (3) tick();
        rxd_drv = 1'b1;
        repeat (40) tick();
        bus_read(2'd1, rd); check("glitch_status", rd, 32'h0);
        check("glitch_rx_idle", {30'b0, rx_state}, 32'h0);

        // Pop on the exact completion edge of a new byte
        s0 = cyc;
        fork
            send_rx(8'h11, 1'b1);
            wait_rx_valid(300, at);
        join
        lat = at - s0;
        check("rx_latency_window", {31'b0, lat >= 153 && lat <= 156}, 32'h1);
        repeat (20) tick();
        s0 = cyc;
        fork
            send_rx(8'h22, 1'b1);
            begin
                goto_cyc(s0 + lat - 1);
                bus_pop();
            end
        join
        repeat (4) tick();
        bus_read(2'd1, rd); check("simul_pop_status", rd, 32'h02);
        bus_read(2'd0, rd); check("simul_pop_data", rd, 32'h22);
        bus_pop();
        bus_read(2'd1, rd); check("final_status", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
